// File: rtl/uart_tx_arb_pkg.sv
// +--------------------------------------------------------------------+
// | uart_tx_arb_pkg : shared types for the UART TX arbiter             |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package uart_tx_arb_pkg;

  localparam int STATE_W = 2;
  localparam int BYTE_W  = 8;

  typedef enum logic [STATE_W-1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    GAP   = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/uart_rr_pick.sv
// +--------------------------------------------------------------------+
// | uart_rr_pick : rotate-priority picker, first request after rr_ptr  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module uart_rr_pick #(
  parameter int N_REQ = 4,
  parameter int PTR_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] rr_ptr,
  output logic [PTR_W-1:0] grant,
  output logic             valid
);

  int cand;

  // Walk offsets from farthest to nearest so the nearest set request wins.
  always_comb begin
    grant = '0;
    cand  = 0;
    valid = |req;
    for (int k = N_REQ; k >= 1; k--) begin
      cand = (int'(rr_ptr) + k) % N_REQ;
      if (req[cand[PTR_W-1:0]]) begin
        grant = cand[PTR_W-1:0];
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
// +--------------------------------------------------------------------+
// | uart_tx_arbiter : round-robin sharing of one UART TX datapath      |
// | Option macro: UART_TX_ARB_LOCK_EN (adds req_lock burst regrant)    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module uart_tx_arbiter
  import uart_tx_arb_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int GAP_TICKS = 1,
  parameter int TMO_TICKS = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  baud_tick,
  input  logic [N_REQ-1:0]      req,
  input  logic [8*N_REQ-1:0]    req_data,
`ifdef UART_TX_ARB_LOCK_EN
  input  logic [N_REQ-1:0]      req_lock,
`endif
  output logic [N_REQ-1:0]      ack,
  output logic [BYTE_W-1:0]     tx_data,
  output logic                  tx_load,
  output logic                  tx_shift_en,
  input  logic                  tx_done,
  output logic                  busy,
  output logic                  tmo_err
);

  localparam int PTR_W  = $clog2(N_REQ);
  localparam int TICK_W = $clog2(TMO_TICKS + 1);
  localparam int GAP_W  = (GAP_TICKS < 1) ? 1 : $clog2(GAP_TICKS + 1);
  localparam logic [TICK_W-1:0] TMO_LAST = TICK_W'(TMO_TICKS);
  localparam logic [GAP_W-1:0]  GAP_LAST = GAP_W'(GAP_TICKS);

  state_t              state, state_n;
  logic [PTR_W-1:0]    rr_ptr, rr_ptr_n;
  logic [N_REQ-1:0]    ack_n;
  logic [BYTE_W-1:0]   tx_data_n;
  logic                tx_load_n, tx_shift_en_n, tmo_err_n;
  logic [TICK_W-1:0]   tick_cnt, tick_cnt_n;
  logic [GAP_W-1:0]    gap_cnt, gap_cnt_n;
  logic [PTR_W-1:0]    pick_idx, grant_idx;
  logic                pick_valid;
  logic [BYTE_W-1:0]   grant_byte;
  logic                frame_end_lock;

  uart_rr_pick #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_pick (
    .req    (req),
    .rr_ptr (rr_ptr),
    .grant  (pick_idx),
    .valid  (pick_valid)
  );

`ifdef UART_TX_ARB_LOCK_EN
  logic lock_hold, lock_hold_n;

  // A locked source keeps the grant; rr_ptr already points at it.
  assign grant_idx      = (lock_hold && req[rr_ptr]) ? rr_ptr : pick_idx;
  assign frame_end_lock = req_lock[rr_ptr] && req[rr_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) lock_hold <= 1'b0;
    else     lock_hold <= lock_hold_n;
  end
`else
  assign grant_idx      = pick_idx;
  assign frame_end_lock = 1'b0;
`endif

  always_comb begin
    grant_byte = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_idx == PTR_W'(i)) grant_byte = req_data[i*BYTE_W +: BYTE_W];
    end
  end

  always_comb begin
    state_n       = state;
    rr_ptr_n      = rr_ptr;
    ack_n         = '0;
    tx_data_n     = tx_data;
    tx_load_n     = 1'b0;
    tx_shift_en_n = tx_shift_en;
    tick_cnt_n    = tick_cnt;
    gap_cnt_n     = gap_cnt;
    tmo_err_n     = tmo_err;
`ifdef UART_TX_ARB_LOCK_EN
    lock_hold_n   = lock_hold;
`endif
    case (state)
      IDLE: begin
        if (pick_valid) begin
          tx_data_n        = grant_byte;
          ack_n[grant_idx] = 1'b1;
          rr_ptr_n         = grant_idx;
          state_n          = LOAD;
`ifdef UART_TX_ARB_LOCK_EN
          lock_hold_n      = 1'b0;
`endif
        end
      end
      LOAD: begin
        tx_load_n     = 1'b1;
        tx_shift_en_n = 1'b1;
        tick_cnt_n    = '0;
        state_n       = SHIFT;
      end
      SHIFT: begin
        if (tx_done) begin
          tx_shift_en_n = 1'b0;
          gap_cnt_n     = '0;
          if (GAP_TICKS == 0) begin
            state_n = IDLE;
`ifdef UART_TX_ARB_LOCK_EN
            lock_hold_n = frame_end_lock;
`endif
          end else begin
            state_n = GAP;
          end
        end else if (tick_cnt == TMO_LAST) begin
          tmo_err_n     = 1'b1;
          tx_shift_en_n = 1'b0;
          state_n       = IDLE;
        end else if (baud_tick) begin
          tick_cnt_n = tick_cnt + 1'b1;
        end
      end
      GAP: begin
        // gap_cnt only advances while below the last tick, so it never wraps.
        if (baud_tick) begin
          if (gap_cnt + 1'b1 >= GAP_LAST) begin
            state_n = IDLE;
`ifdef UART_TX_ARB_LOCK_EN
            lock_hold_n = frame_end_lock;
`endif
          end else begin
            gap_cnt_n = gap_cnt + 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      rr_ptr      <= PTR_W'(N_REQ - 1);
      ack         <= '0;
      tx_data     <= '0;
      tx_load     <= 1'b0;
      tx_shift_en <= 1'b0;
      tick_cnt    <= '0;
      gap_cnt     <= '0;
      tmo_err     <= 1'b0;
    end else begin
      state       <= state_n;
      rr_ptr      <= rr_ptr_n;
      ack         <= ack_n;
      tx_data     <= tx_data_n;
      tx_load     <= tx_load_n;
      tx_shift_en <= tx_shift_en_n;
      tick_cnt    <= tick_cnt_n;
      gap_cnt     <= gap_cnt_n;
      tmo_err     <= tmo_err_n;
    end
  end

  assign busy = (state != IDLE);

  // frame_end_lock feeds only the lock option.
  logic unused_ok;
  assign unused_ok = frame_end_lock;

endmodule

`default_nettype wire
